// File: rtl/egg_timer_pkg.sv
// Shared types and limits for the egg timer countdown engine.
// State encoding, BCD digit limits and the packed BCD pair type.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    typedef logic [7:0] bcd8_t;

    function automatic logic bcd_nonzero(
        input bcd8_t a,
        input bcd8_t b
    );
        return |{a, b};
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown: decrement with borrow-out on the
// 0 -> MAX wrap, and a synchronous load that clamps to MAX.
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       borrow
);

    assign borrow = dec && (digit == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= (load_val > MAX) ? MAX : load_val;
        end else if (dec) begin
            digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/egg_countdown.sv
// BCD MM:SS countdown engine for the egg timer.
// Optional build macro ALARM_FLASH_EN: flashing alarm LED on expiry.
module egg_countdown
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int FLASH_DIV = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] bcd_in,
    input  logic       load_sec,
    input  logic       load_min,
    input  logic       start,
    input  logic       pause,
    output bcd8_t      min_bcd,
    output bcd8_t      sec_bcd,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       alarm_flash
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          done_nxt;
    logic          tick;
    logic          at_one;
    logic          cnt_nz;
    logic          any_ld;
    logic          go;
    logic          ld_ok;

    logic [3:0] s1, s10, m1, m10;
    logic       b_s1, b_s10, b_m1;
    logic       unused_m10_borrow;

    assign tick   = (state == RUN) && (presc == TICK_LAST);
    assign at_one = (min_bcd == 8'h00) && (sec_bcd == 8'h01);
    assign cnt_nz = bcd_nonzero(min_bcd, sec_bcd);
    assign any_ld = load_sec | load_min;
    assign go     = start & ~pause;
    assign ld_ok  = (state != RUN);

    // Borrow chain: seconds ones -> seconds tens -> minutes.
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (load_sec & ld_ok),
        .load_val (bcd_in[3:0]),
        .dec      (tick),
        .digit    (s1),
        .borrow   (b_s1)
    );

    bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (load_sec & ld_ok),
        .load_val (bcd_in[7:4]),
        .dec      (b_s1),
        .digit    (s10),
        .borrow   (b_s10)
    );

    bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (load_min & ld_ok),
        .load_val (bcd_in[3:0]),
        .dec      (b_s10),
        .digit    (m1),
        .borrow   (b_m1)
    );

    bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_tens (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (load_min & ld_ok),
        .load_val (bcd_in[7:4]),
        .dec      (b_m1),
        .digit    (m10),
        .borrow   (unused_m10_borrow)
    );

    assign sec_bcd = {s10, s1};
    assign min_bcd = {m10, m1};

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (go && !any_ld && cnt_nz) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                end
            end
            RUN: begin
                // Every cycle spent in RUN counts, including a pause edge.
                presc_nxt = tick ? '0 : presc + 1'b1;
                if (tick && at_one) begin
                    state_nxt = EXPIRED;
                    done_nxt  = 1'b1;
                end else if (pause) begin
                    state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (go && !any_ld && cnt_nz) begin
                    state_nxt = RUN;
                end
            end
            EXPIRED: begin
                if (any_ld || start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            running <= (state_nxt == RUN);
            done    <= done_nxt;
            expired <= (state_nxt == EXPIRED);
        end
    end

`ifdef ALARM_FLASH_EN
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

    logic [FW-1:0] fcnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fcnt        <= '0;
            alarm_flash <= 1'b0;
        end else if (state_nxt != EXPIRED) begin
            fcnt        <= '0;
            alarm_flash <= 1'b0;
        end else if (state != EXPIRED) begin
            fcnt        <= '0;
            alarm_flash <= 1'b1;
        end else if (fcnt == FLASH_LAST) begin
            fcnt        <= '0;
            alarm_flash <= ~alarm_flash;
        end else begin
            fcnt        <= fcnt + 1'b1;
        end
    end
`else
    localparam int unused_flash_div = FLASH_DIV;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            alarm_flash <= 1'b0;
        end else begin
            alarm_flash <= (state_nxt == EXPIRED);
        end
    end
`endif

endmodule

// File: tb/tb_egg_countdown.sv
// Scoreboard bench for egg_countdown with TICK_DIV=4, FLASH_DIV=2.
// Expected count changes are queued at start and popped on each change.
module tb_egg_countdown;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bcd_in = 8'h00;
    logic       load_sec = 1'b0;
    logic       load_min = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       expired;
    logic       alarm_flash;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] m;
        logic [7:0] s;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    egg_countdown #(.TICK_DIV(4), .FLASH_DIV(2)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .bcd_in      (bcd_in),
        .load_sec    (load_sec),
        .load_min    (load_min),
        .start       (start),
        .pause       (pause),
        .min_bcd     (min_bcd),
        .sec_bcd     (sec_bcd),
        .running     (running),
        .done        (done),
        .expired     (expired),
        .alarm_flash (alarm_flash)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic s, input logic m,
                           input logic [7:0] v);
        bcd_in   = v;
        load_sec = s;
        load_min = m;
        cyc();
        load_sec = 1'b0;
        load_min = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({min_bcd, sec_bcd, running, done, expired, alarm_flash}
            !== 20'h0) begin
            $display("FAIL reset_state got %h %h r%b d%b e%b a%b want 0",
                     min_bcd, sec_bcd, running, done, expired,
                     alarm_flash);
        end else passed++;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_countdown();
        logic [15:0] prev;
        exp_t        e;
        int          dones = 0;
        do_load(1'b1, 1'b0, 8'h05);
        do_load(1'b0, 1'b1, 8'h00);
        do_start();
        checks++;
        if (running !== 1'b1) begin
            $display("FAIL cd_running got %b want 1", running);
        end else passed++;
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{8'h00, to_bcd(5 - k), 4 * k});
        end
        prev = {min_bcd, sec_bcd};
        for (int n = 1; n <= 24; n++) begin
            cyc();
            if ({min_bcd, sec_bcd} !== prev) begin
                prev = {min_bcd, sec_bcd};
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL cd_extra got %h:%h at %0d",
                             min_bcd, sec_bcd, n);
                end else begin
                    e = sb.pop_front();
                    if (min_bcd !== e.m || sec_bcd !== e.s ||
                        n != e.cyc) begin
                        $display("FAIL cd_step got %h:%h@%0d want %h:%h@%0d",
                                 min_bcd, sec_bcd, n, e.m, e.s, e.cyc);
                    end else passed++;
                end
            end
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (sec_bcd !== 8'h00 || n != 20) begin
                    $display("FAIL cd_done_when got sec %h@%0d want 00@20",
                             sec_bcd, n);
                end else passed++;
            end
        end
        checks++;
        if (sb.size() != 0 || dones != 1) begin
            $display("FAIL cd_totals got left %0d dones %0d want 0 1",
                     sb.size(), dones);
        end else passed++;
        checks++;
        if (expired !== 1'b1 || running !== 1'b0) begin
            $display("FAIL cd_expired got e%b r%b want e1 r0",
                     expired, running);
        end else passed++;
        sb.delete();
    endtask

    task automatic test_borrow();
        logic [15:0] prev;
        exp_t        e;
        int          dones = 0;
        int          done_at = -1;
        int          bad = 0;
        do_load(1'b0, 1'b1, 8'h01);
        do_load(1'b1, 1'b0, 8'h00);
        checks++;
        if (expired !== 1'b0 || min_bcd !== 8'h01) begin
            $display("FAIL bw_exit_exp got e%b min %h want e0 01",
                     expired, min_bcd);
        end else passed++;
        do_start();
        for (int k = 1; k <= 60; k++) begin
            sb.push_back('{8'h00, to_bcd(60 - k), 4 * k});
        end
        prev = {min_bcd, sec_bcd};
        for (int n = 1; n <= 250; n++) begin
            cyc();
            if (done === 1'b1) begin
                dones++;
                done_at = n;
            end
            if ({min_bcd, sec_bcd} !== prev) begin
                prev = {min_bcd, sec_bcd};
                if (sb.size() == 0) begin
                    bad++;
                end else begin
                    e = sb.pop_front();
                    if (e.cyc == 4) begin
                        checks++;
                        if (min_bcd !== 8'h00 || sec_bcd !== 8'h59 ||
                            n != 4) begin
                            $display("FAIL bw_first got %h:%h@%0d want 00:59@4",
                                     min_bcd, sec_bcd, n);
                        end else passed++;
                    end else if (min_bcd !== e.m || sec_bcd !== e.s ||
                                 n != e.cyc) begin
                        bad++;
                        $display("FAIL bw_step got %h:%h@%0d want %h:%h@%0d",
                                 min_bcd, sec_bcd, n, e.m, e.s, e.cyc);
                    end
                end
            end
        end
        checks++;
        if (bad != 0 || sb.size() != 0) begin
            $display("FAIL bw_sequence got bad %0d left %0d want 0 0",
                     bad, sb.size());
        end else passed++;
        checks++;
        if (dones != 1 || done_at != 240 || expired !== 1'b1) begin
            $display("FAIL bw_expiry got dones %0d at %0d e%b want 1 240 1",
                     dones, done_at, expired);
        end else passed++;
        sb.delete();
    endtask

    task automatic test_clamp();
        do_load(1'b1, 1'b0, 8'hAF);
        checks++;
        if (sec_bcd !== 8'h59 || expired !== 1'b0) begin
            $display("FAIL clamp_sec_af got %h e%b want 59 e0",
                     sec_bcd, expired);
        end else passed++;
        do_load(1'b0, 1'b1, 8'hFA);
        checks++;
        if (min_bcd !== 8'h99) begin
            $display("FAIL clamp_min_fa got %h want 99", min_bcd);
        end else passed++;
        do_load(1'b1, 1'b0, 8'h7C);
        checks++;
        if (sec_bcd !== 8'h59) begin
            $display("FAIL clamp_sec_7c got %h want 59", sec_bcd);
        end else passed++;
        do_load(1'b1, 1'b1, 8'h23);
        checks++;
        if (min_bcd !== 8'h23 || sec_bcd !== 8'h23) begin
            $display("FAIL dual_load got %h:%h want 23:23",
                     min_bcd, sec_bcd);
        end else passed++;
    endtask

    task automatic test_load_start();
        bcd_in   = 8'h30;
        load_sec = 1'b1;
        start    = 1'b1;
        cyc();
        load_sec = 1'b0;
        start    = 1'b0;
        cyc();
        checks++;
        if (sec_bcd !== 8'h30 || running !== 1'b0) begin
            $display("FAIL load_start got %h r%b want 30 r0",
                     sec_bcd, running);
        end else passed++;
    endtask

    task automatic test_pause();
        logic [15:0] prev;
        exp_t        e;
        int          moved = 0;
        int          hits = 0;
        do_load(1'b0, 1'b1, 8'h00);
        do_load(1'b1, 1'b0, 8'h11);
        do_start();
        for (int n = 1; n <= 4; n++) cyc();
        checks++;
        if (sec_bcd !== 8'h10 || min_bcd !== 8'h00) begin
            $display("FAIL pz_first_tick got %h:%h want 00:10",
                     min_bcd, sec_bcd);
        end else passed++;
        cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        checks++;
        if (running !== 1'b0) begin
            $display("FAIL pz_stopped got r%b want r0", running);
        end else passed++;
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (sec_bcd !== 8'h10) moved++;
        end
        checks++;
        if (moved != 0) begin
            $display("FAIL pz_hold got %0d changed cycles want 0", moved);
        end else passed++;
        do_start();
        checks++;
        if (running !== 1'b1 || sec_bcd !== 8'h10) begin
            $display("FAIL pz_resume got r%b %h want r1 10",
                     running, sec_bcd);
        end else passed++;
        sb.push_back('{8'h00, 8'h09, 2});
        prev = {min_bcd, sec_bcd};
        for (int n = 1; n <= 3; n++) begin
            cyc();
            if ({min_bcd, sec_bcd} !== prev) begin
                prev = {min_bcd, sec_bcd};
                hits++;
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL pz_extra got %h:%h@%0d",
                             min_bcd, sec_bcd, n);
                end else begin
                    e = sb.pop_front();
                    if (min_bcd !== e.m || sec_bcd !== e.s ||
                        n != e.cyc) begin
                        $display("FAIL pz_next got %h:%h@%0d want %h:%h@%0d",
                                 min_bcd, sec_bcd, n, e.m, e.s, e.cyc);
                    end else passed++;
                end
            end
        end
        checks++;
        if (hits != 1 || sb.size() != 0) begin
            $display("FAIL pz_count got %0d changes want 1", hits);
        end else passed++;
        sb.delete();
        start = 1'b1;
        pause = 1'b1;
        cyc();
        start = 1'b0;
        pause = 1'b0;
        checks++;
        if (running !== 1'b0) begin
            $display("FAIL pause_wins got r%b want r0", running);
        end else passed++;
    endtask

    task automatic test_start_zero();
        int seen = 0;
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        cyc();
        do_start();
        for (int n = 0; n < 6; n++) begin
            if (done !== 1'b0 || running !== 1'b0) seen++;
            cyc();
        end
        checks++;
        if (seen != 0 || expired !== 1'b0) begin
            $display("FAIL start_zero got bad %0d e%b want 0 e0",
                     seen, expired);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        do_load(1'b0, 1'b1, 8'h03);
        do_load(1'b1, 1'b0, 8'h27);
        do_start();
        cyc();
        checks++;
        if (running !== 1'b1 || min_bcd !== 8'h03 ||
            sec_bcd !== 8'h27) begin
            $display("FAIL mid_run got r%b %h:%h want r1 03:27",
                     running, min_bcd, sec_bcd);
        end else passed++;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({min_bcd, sec_bcd, running, done, expired, alarm_flash}
            !== 20'h0) begin
            $display("FAIL mid_reset got %h:%h r%b d%b e%b a%b want 0",
                     min_bcd, sec_bcd, running, done, expired,
                     alarm_flash);
        end else passed++;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_flash();
        int wait_n = 0;
        int bad = 0;
        logic want;
        do_load(1'b1, 1'b0, 8'h01);
        do_start();
        while (expired !== 1'b1 && wait_n < 12) begin
            cyc();
            wait_n++;
        end
        checks++;
        if (expired !== 1'b1) begin
            $display("FAIL fl_timeout got e%b want e1", expired);
        end else passed++;
        for (int k = 0; k < 6; k++) begin
`ifdef ALARM_FLASH_EN
            want = ((k / 2) % 2) == 0;
`else
            want = expired;
`endif
            if (alarm_flash !== want) begin
                bad++;
                $display("FAIL fl_seq got %b at %0d want %b",
                         alarm_flash, k, want);
            end
            cyc();
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL fl_pattern got %0d bad cycles want 0", bad);
        end else passed++;
        do_load(1'b1, 1'b0, 8'h42);
        checks++;
        if (alarm_flash !== 1'b0 || expired !== 1'b0 ||
            sec_bcd !== 8'h42 || running !== 1'b0) begin
            $display("FAIL fl_exit got a%b e%b %h r%b want a0 e0 42 r0",
                     alarm_flash, expired, sec_bcd, running);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_clamp();
        test_load_start();
        test_pause();
        test_start_zero();
        test_reset_mid();
        test_flash();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/egg_countdown.md
Name: egg_countdown

Overview:
- BCD MM:SS countdown engine for the egg timer; the producing end of the timer interface whose display/LED side consumes controller state.
- Accepts minute/second settings from the switch bus, counts down at a 1 Hz tick derived from CLOCK_50, and reports expiry back to the controller.
- Outputs feed the 7-segment decoders directly as packed BCD digits.

Parameters:
- TICK_DIV, 50000000, CLOCK_50 cycles per one-second tick; benches override it to a small value.
- FLASH_DIV, 12500000, cycles per alarm_flash half-period; used only with ALARM_FLASH_EN.

Ports:
- CLOCK_50  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- bcd_in  in  8  packed BCD setting {tens, ones}
- load_sec  in  1  one-cycle strobe: capture bcd_in into seconds
- load_min  in  1  one-cycle strobe: capture bcd_in into minutes
- start  in  1  one-cycle strobe: begin or resume counting
- pause  in  1  one-cycle strobe: freeze count
- min_bcd  out  8  current minutes {tens, ones}
- sec_bcd  out  8  current seconds {tens, ones}
- running  out  1  high in RUN
- done  out  1  one-cycle pulse on reaching 00:00
- expired  out  1  high in EXPIRED
- alarm_flash  out  1  LED drive during expiry

Behaviour:
- Reset (async, any time, including mid-count): state IDLE, min_bcd=00, sec_bcd=00, prescaler=0, running=0, done=0, expired=0, alarm_flash=0.
- States: IDLE, RUN, PAUSE, EXPIRED.
- IDLE:
  - load_sec/load_min update the register on the next edge.
  - start with a nonzero count goes to RUN; start at 00:00 is ignored and produces no done.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and is cleared on entry, so the first decrement lands exactly TICK_DIV cycles after the start edge.
  - Tick decrement: sec ones 0->9 borrows from sec tens; sec tens 0->5 borrows from minutes; minutes 00 never wrap.
  - The tick that produces 00:00 moves to EXPIRED with done=1 for that one cycle.
  - pause goes to PAUSE and holds the prescaler value. Loads are ignored.
- PAUSE:
  - start returns to RUN with the prescaler resumed, not cleared.
  - load_sec/load_min are accepted. Resume at 00:00 is ignored.
- EXPIRED: holds 00:00, expired=1. Any load or start returns to IDLE; a load also updates its register on the same edge.
- Input sanitising on load:
  - Any BCD digit >9 clamps to 9.
  - Seconds tens >5 clamps to 5, so 0x7C loads as 0x59.
  - Minutes range 00..99.
- Simultaneous strobes:
  - load_sec and load_min together both load the same bcd_in.
  - start and pause together: pause wins.
  - Load and start in IDLE on the same edge: the load is written and the state stays IDLE.
- Outputs are registered; zero combinational paths from inputs to outputs.

Optional Feature:
- Macro ALARM_FLASH_EN.
- Defined: in EXPIRED, alarm_flash toggles every FLASH_DIV cycles, starting high on the cycle expired rises; it is 0 in all other states.
- Undefined: alarm_flash equals expired, and the flash counter is not synthesised.

Decomposition:
- Shared package egg_timer_pkg holds:
  - the state encoding (IDLE, RUN, PAUSE, EXPIRED, 2 bits);
  - BCD limits (DIGIT_MAX=9, SEC_TENS_MAX=5);
  - the 8-bit packed-BCD type.
- One sub-module bcd_digit_down: 4-bit down counter with MAX parameter, decrement enable, borrow-out on 0->MAX wrap, and synchronous load with clamp. It is instantiated four times.

Test Plan (TICK_DIV=4, FLASH_DIV=2):
- Load sec 0x05, min 0x00, start -> sec_bcd decrements every 4 cycles through 05,04,...,00; done pulses exactly once, on the cycle sec_bcd becomes 00; expired=1 afterwards.
- Load min 0x01, sec 0x00, start -> after 4 cycles reads 00:59, ones borrow passes into the tens, and expiry occurs 60 ticks after start.
- Load bcd_in 0xAF into sec and 0xFA into min -> sec_bcd=0x59 and min_bcd=0x99.
- Running at 00:10: pause 2 cycles after a tick, wait 20 cycles, then start -> next decrement 2 cycles after resume; count unchanged while paused.
- Start at 00:00 -> stays IDLE, running=0, no done. Assert reset mid-count at 03:27 -> all outputs 0 immediately, without waiting for a clock edge.
- With ALARM_FLASH_EN, expire -> alarm_flash toggles every 2 cycles. A following load_sec returns to IDLE and alarm_flash=0. Without the macro, alarm_flash tracks expired.
